// File: rtl/func_bist_ctrl.sv
// -----------------------------------------------------------------------------
// func_bist_ctrl
//   Hardware stimulus/response engine for the Func logic block. A 16-bit
//   Galois LFSR produces pseudo-random vectors on A,B,C,D,Sel. Each vector is
//   held for SETTLE_CYCLES cycles and then checked for one cycle against the
//   golden Func equation. The block counts failing vectors, records the first
//   failing index and reports pass/fail when the run completes.
//
// Ports
//   clk            in   rising-edge clock
//   rst_n          in   asynchronous active-low reset
//   start          in   run request, sampled only in IDLE or DONE
//   Out, Out_bar   in   responses from Func
//   A, B, C, Sel   out  registered stimulus bits
//   D              out  registered 3-bit stimulus
//   busy           out  high while a run is in progress (DRIVE/CHECK)
//   done           out  high in DONE
//   pass           out  valid with done: 1 iff no vector failed
//   err_count      out  failing-vector count, saturating at all-ones
//   vec_idx        out  index of the vector currently applied
//   first_err_vec  out  index of the first failing vector, all-ones if none
//
// Handshake: start is a level request. It is only looked at in IDLE and DONE;
// while busy it is ignored. Holding start high in DONE restarts at once.
// -----------------------------------------------------------------------------
module func_bist_ctrl #(
   parameter int          NUM_VECTORS   = 99,
   parameter int          SETTLE_CYCLES = 1,
   parameter logic [15:0] LFSR_SEED     = 16'hACE1,
   parameter int          CNT_W         = 7,
   parameter int          ERR_W         = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             Out,
   input  logic             Out_bar,
   output logic             A,
   output logic             B,
   output logic             C,
   output logic [2:0]       D,
   output logic             Sel,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic [CNT_W-1:0] vec_idx,
   output logic [CNT_W-1:0] first_err_vec
);

   // Settle counter only needs to reach SETTLE_CYCLES-1.
   localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRIVE = 2'd1,
      S_CHECK = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t           state;
   logic [15:0]      lfsr;
   logic [15:0]      lfsr_next;
   logic [SET_W-1:0] settle_cnt;
   logic             expected;
   logic             vec_fail;
   logic [ERR_W-1:0] err_next;

   always_comb begin
      // Galois right shift, taps x^16+x^14+x^13+x^11+1.
      lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      // Golden Func response for the stimulus currently on the pins.
      expected  = Sel ? ~(A ^ B ^ C) : ((D[0] & D[1]) | D[2]);
      // Both rails must be correct; Out==Out_bar can never pass.
      vec_fail  = (Out != expected) || (Out_bar != ~expected);
      err_next  = err_count;
      if (vec_fail && (err_count != {ERR_W{1'b1}}))
         err_next = err_count + ERR_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         lfsr          <= LFSR_SEED;
         settle_cnt    <= '0;
         A             <= 1'b0;
         B             <= 1'b0;
         C             <= 1'b0;
         D             <= 3'b000;
         Sel           <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         pass          <= 1'b0;
         err_count     <= '0;
         vec_idx       <= '0;
         first_err_vec <= {CNT_W{1'b1}};
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  // Every run restarts from the seed, so a rerun replays
                  // exactly the same vector sequence.
                  state                <= S_DRIVE;
                  lfsr                 <= LFSR_SEED;
                  {Sel, D, C, B, A}    <= LFSR_SEED[6:0];
                  settle_cnt           <= '0;
                  vec_idx              <= '0;
                  err_count            <= '0;
                  first_err_vec        <= {CNT_W{1'b1}};
                  busy                 <= 1'b1;
                  done                 <= 1'b0;
                  pass                 <= 1'b0;
               end
            end

            S_DRIVE: begin
               if (settle_cnt == SET_W'(SETTLE_CYCLES - 1))
                  state <= S_CHECK;
               else
                  settle_cnt <= settle_cnt + SET_W'(1);
            end

            S_CHECK: begin
               err_count <= err_next;
               if (vec_fail && (first_err_vec == {CNT_W{1'b1}}))
                  first_err_vec <= vec_idx;
               if (vec_idx == CNT_W'(NUM_VECTORS - 1)) begin
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (err_next == '0);
               end else begin
                  state             <= S_DRIVE;
                  lfsr              <= lfsr_next;
                  {Sel, D, C, B, A} <= lfsr_next[6:0];
                  vec_idx           <= vec_idx + CNT_W'(1);
                  settle_cnt        <= '0;
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_func_bist_ctrl.sv
// -----------------------------------------------------------------------------
// tb_func_bist_ctrl
//   Bench for func_bist_ctrl. A behavioural Func model responds to the
//   stimulus with a selectable fault mode (golden, Out stuck at 0, Out_bar
//   tied to Out, random per-pattern faults). A second instance with ERR_W=4
//   always sees an inverted Func and must saturate its error count.
//   Expected results come from a reference vector list generated from the
//   LFSR rules and the Func equation.
// -----------------------------------------------------------------------------
module tb_func_bist_ctrl;

   localparam int N      = 99;
   localparam int SETTLE = 1;
   localparam int RUN_CY = N * (SETTLE + 1);

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUT 1 (default widths) ----------------
   logic       A, B, C, Sel, busy, done, pass;
   logic [2:0] D;
   logic [7:0] err_count;
   logic [6:0] vec_idx, first_err_vec;
   logic       out_m, out_bar_m;
   logic [6:0] pat;

   // ---------------- DUT 2 (ERR_W=4, inverted Func) ----------------
   logic       A_x, B_x, C_x, Sel_x, busy_x, done_x, pass_x;
   logic [2:0] D_x;
   logic [3:0] err_count_x;
   logic [6:0] vec_idx_x, first_err_vec_x;
   logic       out_x, out_bar_x;
   logic [6:0] pat_x;

   int           mode = 0;      // 0 golden, 1 Out stuck 0, 2 Out_bar=Out, 3 random faults
   logic [127:0] fault_mask = '0;

   int checks = 0;
   int errors = 0;

   logic [6:0] ref_vec [N];
   logic [6:0] rec_q [$];
   logic [6:0] saved_q [$];

   func_bist_ctrl dut (
      .clk(clk), .rst_n(rst_n), .start(start), .Out(out_m), .Out_bar(out_bar_m),
      .A(A), .B(B), .C(C), .D(D), .Sel(Sel), .busy(busy), .done(done), .pass(pass),
      .err_count(err_count), .vec_idx(vec_idx), .first_err_vec(first_err_vec)
   );

   func_bist_ctrl #(.ERR_W(4)) dut_sat (
      .clk(clk), .rst_n(rst_n), .start(start), .Out(out_x), .Out_bar(out_bar_x),
      .A(A_x), .B(B_x), .C(C_x), .D(D_x), .Sel(Sel_x), .busy(busy_x), .done(done_x),
      .pass(pass_x), .err_count(err_count_x), .vec_idx(vec_idx_x),
      .first_err_vec(first_err_vec_x)
   );

   // Func equation on a packed pattern {Sel, D[2:0], C, B, A}.
   function automatic logic golden(input logic [6:0] p);
      if (p[6])
         return ~(p[0] ^ p[1] ^ p[2]);
      return (p[3] & p[4]) | p[5];
   endfunction

   assign pat   = {Sel, D, C, B, A};
   assign pat_x = {Sel_x, D_x, C_x, B_x, A_x};

   // Behavioural Func with fault injection.
   always_comb begin
      out_m     = golden(pat);
      out_bar_m = ~golden(pat);
      case (mode)
         1: begin out_m = 1'b0; out_bar_m = 1'b1; end
         2: begin out_m = golden(pat); out_bar_m = golden(pat); end
         3: begin out_m = golden(pat) ^ fault_mask[pat]; out_bar_m = ~(golden(pat) ^ fault_mask[pat]); end
         default: ;
      endcase
   end

   assign out_x     = ~golden(pat_x);
   assign out_bar_x = golden(pat_x);

   // Record each newly applied vector once.
   always @(negedge clk) begin
      if (busy && (rec_q.size() == int'(vec_idx)))
         rec_q.push_back(pat);
   end

   // ---------------- scoreboard helpers ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference vector list straight from the LFSR definition.
   task automatic build_ref();
      logic [15:0] l;
      l = 16'hACE1;
      for (int i = 0; i < N; i++) begin
         ref_vec[i] = l[6:0];
         l = (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
      end
   endtask

   // Expected error count and first failing index for a fault mode.
   task automatic expect_run(input int m, output int e_err, output int e_first);
      logic g, o, ob;
      e_err   = 0;
      e_first = 127;
      for (int i = 0; i < N; i++) begin
         g  = golden(ref_vec[i]);
         o  = g;
         ob = ~g;
         if (m == 1) begin o = 1'b0; ob = 1'b1; end
         if (m == 2) begin ob = g; end
         if (m == 3) begin o = g ^ fault_mask[ref_vec[i]]; ob = ~o; end
         if ((o != g) || (ob != ~g)) begin
            if (e_err < 255) e_err++;
            if (e_first == 127) e_first = i;
         end
      end
   endtask

   // Issue start and wait (bounded) for done. start stays high for hold
   // extra cycles after the sampling edge.
   task automatic do_run(input int hold, output int cycles);
      rec_q.delete();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      check("leave_done.done_pass", {30'd0, done, pass}, 32'd0);
      check("start.busy", {31'd0, busy}, 32'd1);
      cycles = 0;
      while (!done && cycles < 5000) begin
         if (cycles >= hold) start = 1'b0;
         @(posedge clk);
         cycles++;
         #1;
      end
      start = 1'b0;
   endtask

   task automatic check_run(input string tag, input int m, input int cycles);
      int e_err, e_first, mism;
      expect_run(m, e_err, e_first);
      check({tag, ".cycles"},    cycles, RUN_CY);
      check({tag, ".done"},      {31'd0, done}, 32'd1);
      check({tag, ".busy"},      {31'd0, busy}, 32'd0);
      check({tag, ".err_count"}, {24'd0, err_count}, e_err);
      check({tag, ".first_err"}, {25'd0, first_err_vec}, e_first);
      check({tag, ".pass"},      {31'd0, pass}, (e_err == 0) ? 32'd1 : 32'd0);
      mism = 0;
      for (int i = 0; i < N; i++)
         if (i >= rec_q.size() || rec_q[i] !== ref_vec[i]) mism++;
      check({tag, ".seq_mismatches"}, mism, 0);
      check({tag, ".seq_len"}, rec_q.size(), N);
      check({tag, ".sat.err_count"}, {28'd0, err_count_x}, 32'hF);
      check({tag, ".sat.first_err"}, {25'd0, first_err_vec_x}, 32'd0);
      check({tag, ".sat.pass_done"}, {30'd0, pass_x, done_x}, 32'd1);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int cyc;
      int hold;
      int wait_cy;
      build_ref();

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      check("rst.stim",      {25'd0, pat}, 32'd0);
      check("rst.flags",     {29'd0, busy, done, pass}, 32'd0);
      check("rst.err_count", {24'd0, err_count}, 32'd0);
      check("rst.vec_idx",   {25'd0, vec_idx}, 32'd0);
      check("rst.first_err", {25'd0, first_err_vec}, 32'h7F);
      check("rst.sat",       {24'd0, err_count_x, 1'b0, busy_x, done_x, pass_x}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat ($urandom_range(1, 6)) @(posedge clk);

      // Golden Func.
      mode = 0;
      do_run(0, cyc);
      check_run("golden", 0, cyc);

      // DONE holds stimulus and counts.
      repeat ($urandom_range(2, 10)) @(posedge clk);
      #1;
      check("done_hold.stim",    {25'd0, pat}, ref_vec[N-1]);
      check("done_hold.vec_idx", {25'd0, vec_idx}, N - 1);
      check("done_hold.sat_idx", {25'd0, vec_idx_x}, N - 1);
      check("done_hold.done",    {31'd0, done}, 32'd1);

      // Out stuck at 0 (restart from DONE).
      mode = 1;
      do_run(0, cyc);
      check_run("stuck0", 1, cyc);

      // Out_bar tied to Out: every vector fails.
      mode = 2;
      do_run(0, cyc);
      check_run("tied", 2, cyc);

      // start held high during the run is ignored; rerun replays the sequence.
      mode = 0;
      hold = $urandom_range(1, 150);
      do_run(hold, cyc);
      check_run("hold_start", 0, cyc);
      saved_q = rec_q;
      do_run(0, cyc);
      check_run("replay", 0, cyc);
      check("replay.identical", (saved_q == rec_q) ? 32'd1 : 32'd0, 32'd1);

      // Random per-pattern faults.
      for (int k = 0; k < 3; k++) begin
         fault_mask = {$urandom, $urandom, $urandom, $urandom};
         if (k == 2) fault_mask = fault_mask & {$urandom, $urandom, $urandom, $urandom};
         mode = 3;
         do_run(0, cyc);
         check_run($sformatf("rand%0d", k), 3, cyc);
      end

      // Asynchronous reset in the middle of vector 40.
      mode = 0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start   = 1'b0;
      wait_cy = 0;
      while (vec_idx != 7'd40 && wait_cy < 1000) begin
         @(posedge clk);
         wait_cy++;
         #1;
      end
      check("midrst.reached_vec40", {25'd0, vec_idx}, 32'd40);
      #($urandom_range(1, 3));
      rst_n = 1'b0;
      #1;
      check("midrst.stim",      {25'd0, pat}, 32'd0);
      check("midrst.flags",     {29'd0, busy, done, pass}, 32'd0);
      check("midrst.err_idx",   {17'd0, err_count, vec_idx}, 32'd0);
      check("midrst.first_err", {25'd0, first_err_vec}, 32'h7F);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat ($urandom_range(1, 4)) @(posedge clk);
      #1;
      check("midrst.idle", {29'd0, busy, done, pass}, 32'd0);
      do_run(0, cyc);
      check_run("after_rst", 0, cyc);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
